// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector: latches each coverage point on its first hit and drains new cover indices over valid/ready.
// Optional COVER_HIT_COUNT_EN macro adds covered_cnt, the number of covered points.
module cover_toggle_collector #(
    parameter int WIDTH       = 40,
    parameter int COVER_INDEX = 0,
    parameter int COVER_TOTAL = 38253,
    parameter int IDX_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             pending_any
`ifdef COVER_HIT_COUNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] covered_cnt
`endif
);
    localparam int SEL_W = WIDTH > 1 ? $clog2(WIDTH) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    logic [WIDTH-1:0]   seen, pending, seen_eff, new_hits, take;
    logic [SEL_W-1:0]   sel;
    logic               load;

    always_comb begin
        sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            sel = pending[i] ? SEL_W'(i) : sel;
    end

    assign seen_eff    = clear ? '0 : seen;
    assign new_hits    = valid & ~seen_eff;
    assign load        = |pending && (state == EMPTY || out_ready);
    assign take        = load ? WIDTH'(1) << sel : '0;
    assign out_valid   = state == FULL;
    assign pending_any = |pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            seen      <= '0;
            pending   <= '0;
            state     <= EMPTY;
            out_index <= '0;
        end else begin
            seen    <= seen_eff | valid;
            pending <= (clear ? '0 : pending & ~take) | new_hits;
            // A load refills the output; an accepted index with nothing pending empties it.
            if (load) begin
                state     <= FULL;
                out_index <= IDX_W'(COVER_INDEX) + IDX_W'(sel);
            end else if (state == FULL && out_ready) begin
                state <= EMPTY;
            end
        end
    end

`ifdef COVER_HIT_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset)
            covered_cnt <= '0;
        else
            covered_cnt <= $bits(covered_cnt)'($countones(seen_eff | valid));
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset)
            assert (COVER_INDEX + WIDTH <= COVER_TOTAL);
    end
endmodule

// File: tb/tb_cover_toggle_collector.sv
// tb_cover_toggle_collector: directed vectors, expected indices queued at stimulus and checked by a handshake monitor.
module tb_cover_toggle_collector;
    localparam int WIDTH = 40;
    localparam int BASE  = 100;

    logic             clock = 0;
    logic             reset = 1;
    logic [WIDTH-1:0] valid = '0;
    logic             clear = 0;
    logic             out_valid;
    logic             out_ready = 0;
    logic [31:0]      out_index;
    logic             pending_any;
`ifdef COVER_HIT_COUNT_EN
    logic [5:0]       covered_cnt;
`endif

    int vectors = 0;
    int errs    = 0;
    int exp_q[$];

    cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(BASE), .COVER_TOTAL(38253), .IDX_W(32)) dut (
        .clock(clock), .reset(reset), .valid(valid), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .pending_any(pending_any)
`ifdef COVER_HIT_COUNT_EN
        , .covered_cnt(covered_cnt)
`endif
    );

    always #5 clock = ~clock;

    // The handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_index got %0d expected none", out_index);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (out_index != 32'(e)) begin
                    errs++;
                    $display("FAIL drain_order got %0d expected %0d", out_index, e);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errs++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        valid = '0;
        clear = 0;
        tick(2);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_index", int'(out_index), 0);
        check("reset_pending_any", int'(pending_any), 0);
`ifdef COVER_HIT_COUNT_EN
        check("reset_covered_cnt", int'(covered_cnt), 0);
`endif
        reset = 0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string name);
        check({name, "_leftover"}, exp_q.size(), 0);
        check({name, "_pending_any"}, int'(pending_any), 0);
    endtask

    initial begin
        // Single point: report two edges after the strobe, exactly once.
        do_reset();
        out_ready = 1;
        valid = WIDTH'(1) << 5;
        exp_q.push_back(105);
        tick();
        valid = '0;
        check("lat_not_early", int'(out_valid), 0);
        check("lat_pending", int'(pending_any), 1);
        tick();
        check("lat_valid", int'(out_valid), 1);
        check("lat_index", int'(out_index), 105);
        tick();
        check("lat_one_cycle", int'(out_valid), 0);
        tick(4);
        check_drained("single");

        // Two simultaneous hits drain in ascending order, back to back.
        do_reset();
        out_ready = 1;
        valid = WIDTH'(9);
        exp_q.push_back(100);
        exp_q.push_back(103);
        tick();
        valid = '0;
        tick();
        check("pair_first", int'(out_index), 100);
        check("pair_pend_after_first", int'(pending_any), 1);
        tick();
        check("pair_second", int'(out_index), 103);
        check("pair_pend_after_second", int'(pending_any), 0);
        tick(3);
        check_drained("pair");

        // Repeated hits of one point report once.
        do_reset();
        out_ready = 1;
        valid = WIDTH'(1) << 7;
        exp_q.push_back(107);
        tick(10);
        valid = '0;
        tick(4);
        check_drained("repeat");
`ifdef COVER_HIT_COUNT_EN
        check("repeat_cnt", int'(covered_cnt), 1);
`endif

        // Backpressure holds the lowest index, then three drain consecutively.
        do_reset();
        out_ready = 0;
        valid = (WIDTH'(1) << 1) | (WIDTH'(1) << 4) | (WIDTH'(1) << 9);
        exp_q.push_back(101);
        exp_q.push_back(104);
        exp_q.push_back(109);
        tick();
        valid = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", int'(out_valid), 1);
            check("stall_index", int'(out_index), 101);
        end
        out_ready = 1;
        tick();
        check("burst_1", int'(out_index), 104);
        tick();
        check("burst_2", int'(out_index), 109);
        tick();
        check("burst_end", int'(out_valid), 0);
        tick(2);
        check_drained("stall");
`ifdef COVER_HIT_COUNT_EN
        check("stall_cnt", int'(covered_cnt), 3);
`endif

        // Clear while presenting: presented index survives, point re-armed.
        do_reset();
        out_ready = 0;
        valid = WIDTH'(1) << 2;
        exp_q.push_back(102);
        tick(2);
        valid = '0;
        check("pre_clear_index", int'(out_index), 102);
        clear = 1;
        valid = WIDTH'(1) << 2;
        exp_q.push_back(102);
        tick();
        clear = 0;
        valid = '0;
        check("clear_hold_valid", int'(out_valid), 1);
        check("clear_hold_index", int'(out_index), 102);
        check("clear_rearmed", int'(pending_any), 1);
        out_ready = 1;
        tick();
        check("rearm_valid", int'(out_valid), 1);
        check("rearm_index", int'(out_index), 102);
        tick();
        check("rearm_once", int'(out_valid), 0);
        tick(2);
        check_drained("clear");
`ifdef COVER_HIT_COUNT_EN
        check("clear_cnt", int'(covered_cnt), 1);
`endif

        // Reset mid-drain drops everything.
        do_reset();
        out_ready = 0;
        valid = WIDTH'(6'h3f) << 10;
        tick();
        valid = '0;
        tick();
        check("pre_reset_valid", int'(out_valid), 1);
        check("pre_reset_pending", int'(pending_any), 1);
        reset = 1;
        tick();
        check("mid_reset_valid", int'(out_valid), 0);
        check("mid_reset_pending", int'(pending_any), 0);
`ifdef COVER_HIT_COUNT_EN
        check("mid_reset_cnt", int'(covered_cnt), 0);
`endif
        reset = 0;
        out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_stale", int'(out_valid), 0);
        end
        check_drained("reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
